// File: rtl/exec_hazard_controller.sv
// Issue/interlock controller ahead of EX: load-use stall, branch squash/redirect, HALT freeze; perf counters under HAZ_PERF_CNT_EN.
// Latency: issue/stall are combinational; flush, redirect and halted follow one edge after the triggering event.
// Backpressure: stall holds IF/ID and presents a NOP to EX; issue is never raised while stalled, flushing or halted.
module exec_hazard_controller #(
  parameter int WIDTH       = 32,
  parameter int LOAD_LAT    = 2,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_is_load,
  input  logic             id_is_halt,
  input  logic             ex_is_branch,
  input  logic [WIDTH-3:0] ex_branch_addr,
  output logic             issue,
  output logic             stall,
  output logic             flush,
  output logic             redirect_valid,
  output logic [WIDTH-3:0] redirect_pc,
  output logic             halted,
  output logic [31:0]      stall_count,
  output logic [31:0]      flush_count
);

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

  state_t        state, state_nxt;
  logic [2:0]    flush_cnt, flush_cnt_nxt;
  logic [LOAD_LAT-1:0] sb_vld;
  logic [4:0]    sb_rd [LOAD_LAT];
  logic          hazard;

  // Scoreboard entries never hold r0, but the explicit r0 guard keeps the intent obvious.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (sb_vld[i] &&
          ((id_uses_rs && id_rs != 5'd0 && sb_rd[i] == id_rs) ||
           (id_uses_rt && id_rt != 5'd0 && sb_rd[i] == id_rt)))
        hazard = 1'b1;
    end
    hazard = hazard && id_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      flush_cnt      <= 3'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      sb_vld         <= '0;
      for (int i = 0; i < LOAD_LAT; i++) sb_rd[i] <= 5'd0;
    end else begin
      state          <= state_nxt;
      flush_cnt      <= flush_cnt_nxt;
      redirect_valid <= ex_is_branch && (state != HALT);
      if (ex_is_branch && (state != HALT)) redirect_pc <= ex_branch_addr;
      for (int i = LOAD_LAT - 1; i > 0; i--) begin
        sb_vld[i] <= sb_vld[i-1];
        sb_rd[i]  <= sb_rd[i-1];
      end
      sb_vld[0] <= issue && id_is_load && (id_rd != 5'd0);
      sb_rd[0]  <= id_rd;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      RUN: begin
        if (ex_is_branch) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = 3'(FLUSH_DEPTH);
        end else if (issue && id_is_halt) begin
          state_nxt = HALT;
        end
      end
      FLUSH: begin
        if (ex_is_branch) begin
          flush_cnt_nxt = 3'(FLUSH_DEPTH);
        end else if (flush_cnt == 3'd1) begin
          state_nxt = RUN;
        end else begin
          flush_cnt_nxt = flush_cnt - 3'd1;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    issue  = (state == RUN) && id_valid && !hazard && !ex_is_branch;
    stall  = (state == RUN) && hazard && !ex_is_branch;
    flush  = (state == FLUSH);
    halted = (state == HALT);
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = 32'd0;
  assign flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_exec_hazard_controller.sv
// Directed per-cycle vector table for exec_hazard_controller plus a counter sequence.
module tb_exec_hazard_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_uses_rs, id_uses_rt, id_is_load, id_is_halt, ex_is_branch;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [29:0] ex_branch_addr;
  logic        issue, stall, flush, redirect_valid, halted;
  logic [29:0] redirect_pc;
  logic [31:0] stall_count, flush_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exec_hazard_controller #(.WIDTH(32), .LOAD_LAT(2), .FLUSH_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_is_load(id_is_load), .id_is_halt(id_is_halt), .ex_is_branch(ex_is_branch),
    .ex_branch_addr(ex_branch_addr), .issue(issue), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  typedef struct {
    logic        rst, vld;
    logic [4:0]  rs, rt;
    logic        urs, urt;
    logic [4:0]  rd;
    logic        ld, hlt, br;
    logic [29:0] baddr;
    logic        e_iss, e_stl, e_fl, e_rv;
    logic [29:0] e_rpc;
    logic        e_h;
  } vec_t;

  function automatic vec_t mk(input logic rst, vld, input logic [4:0] rs, rt,
                              input logic urs, urt, input logic [4:0] rd,
                              input logic ld, hlt, br, input logic [29:0] baddr,
                              input logic iss, stl, fl, rv, input logic [29:0] rpc,
                              input logic h);
    vec_t v;
    v.rst = rst; v.vld = vld; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.rd = rd; v.ld = ld; v.hlt = hlt; v.br = br; v.baddr = baddr;
    v.e_iss = iss; v.e_stl = stl; v.e_fl = fl; v.e_rv = rv; v.e_rpc = rpc; v.e_h = h;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and compare outputs before the next rising edge.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    reset = v.rst; id_valid = v.vld; id_rs = v.rs; id_rt = v.rt;
    id_uses_rs = v.urs; id_uses_rt = v.urt; id_rd = v.rd; id_is_load = v.ld;
    id_is_halt = v.hlt; ex_is_branch = v.br; ex_branch_addr = v.baddr;
    #1;
    check("issue",          idx, {31'd0, issue},          {31'd0, v.e_iss});
    check("stall",          idx, {31'd0, stall},          {31'd0, v.e_stl});
    check("flush",          idx, {31'd0, flush},          {31'd0, v.e_fl});
    check("redirect_valid", idx, {31'd0, redirect_valid}, {31'd0, v.e_rv});
    check("redirect_pc",    idx, {2'd0, redirect_pc},     {2'd0, v.e_rpc});
    check("halted",         idx, {31'd0, halted},         {31'd0, v.e_h});
  endtask

  vec_t tbl [36];
  vec_t seq [10];
  logic [31:0] exp_stall_cnt, exp_flush_cnt;

  initial begin
    //            rst vld rs rt urs urt rd ld hlt br baddr   iss stl fl rv rpc    h
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 30'h0,   0, 0, 0, 0, 30'h0,  0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 30'h0,   1, 0, 0, 0, 30'h0,  0);
    tbl[2]  = mk(0, 1, 5, 0, 1, 0, 8, 0, 0, 0, 30'h0,   0, 1, 0, 0, 30'h0,  0);
    tbl[3]  = mk(0, 1, 5, 0, 1, 0, 8, 0, 0, 0, 30'h0,   0, 1, 0, 0, 30'h0,  0);
    tbl[4]  = mk(0, 1, 5, 0, 1, 0, 8, 0, 0, 0, 30'h0,   1, 0, 0, 0, 30'h0,  0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 30'h0,   1, 0, 0, 0, 30'h0,  0);
    tbl[6]  = mk(0, 1, 0, 0, 1, 0, 8, 0, 0, 0, 30'h0,   1, 0, 0, 0, 30'h0,  0);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 30'h0,   1, 0, 0, 0, 30'h0,  0);
    tbl[8]  = mk(0, 1, 1, 7, 1, 0, 8, 0, 0, 0, 30'h0,   1, 0, 0, 0, 30'h0,  0);
    tbl[9]  = mk(0, 1, 1, 7, 1, 1, 8, 0, 0, 0, 30'h0,   0, 1, 0, 0, 30'h0,  0);
    tbl[10] = mk(0, 1, 1, 7, 1, 1, 8, 0, 0, 0, 30'h0,   1, 0, 0, 0, 30'h0,  0);
    tbl[11] = mk(0, 1, 2, 3, 1, 1, 8, 0, 0, 1, 30'h40,  0, 0, 0, 0, 30'h0,  0);
    tbl[12] = mk(0, 1, 2, 3, 1, 1, 8, 0, 0, 0, 30'h0,   0, 0, 1, 1, 30'h40, 0);
    tbl[13] = mk(0, 1, 2, 3, 1, 1, 8, 0, 0, 1, 30'h80,  0, 0, 1, 0, 30'h40, 0);
    tbl[14] = mk(0, 1, 2, 3, 1, 1, 8, 0, 0, 0, 30'h0,   0, 0, 1, 1, 30'h80, 0);
    tbl[15] = mk(0, 1, 2, 3, 1, 1, 8, 0, 0, 0, 30'h0,   0, 0, 1, 0, 30'h80, 0);
    tbl[16] = mk(0, 1, 2, 3, 1, 1, 8, 0, 0, 0, 30'h0,   1, 0, 0, 0, 30'h80, 0);
    tbl[17] = mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 30'h0,   1, 0, 0, 0, 30'h80, 0);
    tbl[18] = mk(0, 1, 9, 0, 1, 0, 8, 0, 0, 1, 30'h10,  0, 0, 0, 0, 30'h80, 0);
    tbl[19] = mk(0, 1, 9, 0, 1, 0, 8, 0, 0, 0, 30'h0,   0, 0, 1, 1, 30'h10, 0);
    tbl[20] = mk(0, 1, 9, 0, 1, 0, 8, 0, 0, 0, 30'h0,   0, 0, 1, 0, 30'h10, 0);
    tbl[21] = mk(0, 1, 9, 0, 1, 0, 8, 0, 0, 0, 30'h0,   1, 0, 0, 0, 30'h10, 0);
    tbl[22] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 30'h20,  0, 0, 0, 0, 30'h10, 0);
    tbl[23] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 30'h0,   0, 0, 1, 1, 30'h20, 0);
    tbl[24] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 30'h0,   0, 0, 1, 0, 30'h20, 0);
    tbl[25] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 30'h0,   1, 0, 0, 0, 30'h20, 0);
    tbl[26] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 30'h44,  0, 0, 0, 0, 30'h20, 1);
    tbl[27] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 30'h0,   0, 0, 0, 0, 30'h20, 1);
    tbl[28] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 30'h0,   0, 0, 0, 0, 30'h20, 1);
    tbl[29] = mk(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 30'h0,   1, 0, 0, 0, 30'h0,  0);
    tbl[30] = mk(0, 1, 4, 0, 1, 0, 8, 0, 0, 1, 30'h50,  0, 0, 0, 0, 30'h0,  0);
    tbl[31] = mk(1, 1, 4, 0, 1, 0, 8, 0, 0, 0, 30'h0,   0, 0, 1, 1, 30'h50, 0);
    tbl[32] = mk(0, 1, 4, 0, 1, 0, 8, 0, 0, 0, 30'h0,   1, 0, 0, 0, 30'h0,  0);
    tbl[33] = mk(0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 30'h0,   1, 0, 0, 0, 30'h0,  0);
    tbl[34] = mk(1, 1, 6, 0, 1, 0, 8, 0, 0, 0, 30'h0,   0, 1, 0, 0, 30'h0,  0);
    tbl[35] = mk(0, 1, 6, 0, 1, 0, 8, 0, 0, 0, 30'h0,   1, 0, 0, 0, 30'h0,  0);

    // Counter sequence: two load-use stall cycles, then one branch giving two flush cycles.
    seq[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 30'h0,   0, 0, 0, 0, 30'h0,  0);
    seq[1]  = mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 30'h0,   1, 0, 0, 0, 30'h0,  0);
    seq[2]  = mk(0, 1, 5, 0, 1, 0, 8, 0, 0, 0, 30'h0,   0, 1, 0, 0, 30'h0,  0);
    seq[3]  = mk(0, 1, 5, 0, 1, 0, 8, 0, 0, 0, 30'h0,   0, 1, 0, 0, 30'h0,  0);
    seq[4]  = mk(0, 1, 5, 0, 1, 0, 8, 0, 0, 0, 30'h0,   1, 0, 0, 0, 30'h0,  0);
    seq[5]  = mk(0, 1, 0, 0, 0, 0, 8, 0, 0, 1, 30'h30,  0, 0, 0, 0, 30'h0,  0);
    seq[6]  = mk(0, 1, 0, 0, 0, 0, 8, 0, 0, 0, 30'h0,   0, 0, 1, 1, 30'h30, 0);
    seq[7]  = mk(0, 1, 0, 0, 0, 0, 8, 0, 0, 0, 30'h0,   0, 0, 1, 0, 30'h30, 0);
    seq[8]  = mk(0, 1, 0, 0, 0, 0, 8, 0, 0, 0, 30'h0,   1, 0, 0, 0, 30'h30, 0);
    seq[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 30'h0,   0, 0, 0, 0, 30'h30, 0);

`ifdef HAZ_PERF_CNT_EN
    exp_stall_cnt = 32'd2;
    exp_flush_cnt = 32'd2;
`else
    exp_stall_cnt = 32'd0;
    exp_flush_cnt = 32'd0;
`endif

    reset = 1'b1; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0;
    id_uses_rt = 1'b0; id_rd = 5'd0; id_is_load = 1'b0; id_is_halt = 1'b0;
    ex_is_branch = 1'b0; ex_branch_addr = 30'h0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 36; i++) apply(tbl[i], i);

    apply(seq[0], 100);
    apply(seq[1], 101);
    check("stall_count_reset", 101, stall_count, 32'd0);
    check("flush_count_reset", 101, flush_count, 32'd0);
    for (int i = 2; i < 10; i++) begin
      apply(seq[i], 100 + i);
      if (i == 4) check("stall_count", i, stall_count, exp_stall_cnt);
    end
    check("flush_count", 9, flush_count, exp_flush_cnt);
    check("stall_count_hold", 9, stall_count, exp_stall_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
